motor_cmd_sched: RTL and testbench

Command sequencer between the SPI slave and the PWM bank. It detects each completed SPI word, decodes it, and applies it to the per-motor PWM period table, one entry per cycle. It also stages the response word shifted out on the next SPI transaction. It replaces direct `data_ready`-driven period loading in `top_level`.

---
 rtl/motor_cmd_sched.sv | 225 ++++++++++++++++++++++
 tb/tb_motor_cmd_sched.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_cmd_sched.sv
// motor_cmd_sched: SPI command sequencer that decodes each received word and updates the PWM period table.
// Define MOTOR_CMD_RAMP_EN to ramp table entries toward per-motor targets instead of writing them directly.
module motor_cmd_sched #(
    parameter int unsigned NUM_MOTORS     = 24,
    parameter int unsigned PERIOD_W       = 11,
    parameter int unsigned DEFAULT_PERIOD = 1,
    parameter int unsigned RAMP_DIV       = 1024
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           data_ready,
    input  logic [31:0]                    cmd_word,
    input  logic [31:0]                    enc_status,
    output logic [31:0]                    resp_word,
    output logic [NUM_MOTORS*PERIOD_W-1:0] periods,
    output logic                           period_upd,
    output logic [4:0]                     upd_addr,
    output logic                           busy,
    output logic [7:0]                     err_count
);

    localparam logic [7:0] OP_WRITE = 8'h00;
    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_BCAST = 8'h02;
    localparam logic [4:0] LAST_IDX = 5'(NUM_MOTORS - 1);
    localparam logic [PERIOD_W-1:0] DEF_P = PERIOD_W'(DEFAULT_PERIOD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_DECODE,
        S_WRITE,
        S_BCAST
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_dr_s1, r_dr_s2, r_dr_s3;
    logic                w_rdy_evt;
    logic                r_pend;
    logic                r_busy;
    logic [31:0]         r_cmd_q;
    logic [4:0]          r_idx;
    logic [7:0]          r_err;
    logic [31:0]         r_resp;
    logic [PERIOD_W-1:0] r_tbl [NUM_MOTORS];

    logic [7:0]          w_op;
    logic [4:0]          w_motor;
    logic [7:0]          w_raddr;
    logic [PERIOD_W-1:0] w_wr_val;
    logic                w_wr_ok;
    logic                w_rd_ok;
    logic                w_dec_err;
    logic                w_drop;
    logic                w_wr_en;
    logic [4:0]          w_wr_addr;
    logic [1:0]          w_err_inc;
    logic [8:0]          w_err_sum;
    logic                w_unused_cmd;

    assign w_rdy_evt = r_dr_s2 & ~r_dr_s3;

    assign w_op         = r_cmd_q[31:24];
    assign w_motor      = r_cmd_q[20:16];
    assign w_raddr      = r_cmd_q[23:16];
    assign w_wr_val     = PERIOD_W'(r_cmd_q[10:0]);
    assign w_unused_cmd = ^r_cmd_q[15:11];

    assign w_wr_ok   = (w_op == OP_WRITE) && ({27'd0, w_motor} < NUM_MOTORS);
    assign w_rd_ok   = (w_op == OP_READ) && (w_raddr <= 8'h01);
    assign w_dec_err = (r_state == S_DECODE) && !(w_wr_ok || w_rd_ok || (w_op == OP_BCAST));
    // A second event arriving while one is already queued is lost.
    assign w_drop    = w_rdy_evt && (r_state != S_IDLE) && r_pend;

    assign w_err_inc = {1'b0, w_dec_err} + {1'b0, w_drop};
    assign w_err_sum = {1'b0, r_err} + {7'd0, w_err_inc};

    always_comb begin
        w_next    = r_state;
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        case (r_state)
            S_IDLE: begin
                if (w_rdy_evt || r_pend) w_next = S_CAPTURE;
            end
            S_CAPTURE: w_next = S_DECODE;
            S_DECODE: begin
                if (w_wr_ok)                w_next = S_WRITE;
                else if (w_op == OP_BCAST)  w_next = S_BCAST;
                else                        w_next = S_IDLE;
            end
            S_WRITE: begin
                w_wr_en   = 1'b1;
                w_wr_addr = w_motor;
                w_next    = S_IDLE;
            end
            S_BCAST: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_idx;
                if (r_idx == LAST_IDX) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dr_s1 <= 1'b0;
            r_dr_s2 <= 1'b0;
            r_dr_s3 <= 1'b0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pend  <= 1'b0;
            r_cmd_q <= '0;
            r_idx   <= '0;
            r_err   <= '0;
            r_resp  <= '0;
        end else begin
            r_dr_s1 <= data_ready;
            r_dr_s2 <= r_dr_s1;
            r_dr_s3 <= r_dr_s2;
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);

            if (r_state == S_CAPTURE) r_cmd_q <= cmd_word;

            if (r_state == S_DECODE)     r_idx <= '0;
            else if (r_state == S_BCAST) r_idx <= r_idx + 5'd1;

            if ((r_state == S_IDLE) && (w_next == S_CAPTURE)) r_pend <= 1'b0;
            else if (w_rdy_evt && (r_state != S_IDLE))         r_pend <= 1'b1;

            r_err <= w_err_sum[8] ? 8'hFF : w_err_sum[7:0];

            if (w_dec_err)
                r_resp <= {16'hDEAD, w_op, 8'h00};
            else if (w_drop)
                r_resp <= {16'hDEAD, cmd_word[31:24], 8'h00};
            else if ((r_state == S_DECODE) && w_rd_ok)
                r_resp <= (w_raddr == 8'h00) ? enc_status : {16'h0000, r_err, 7'd0, r_pend};
        end
    end

`ifdef MOTOR_CMD_RAMP_EN
    localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [PERIOD_W-1:0]   r_tgt [NUM_MOTORS];
    logic [DIV_W-1:0]      r_div;
    logic [NUM_MOTORS-1:0] r_chg;
    logic [4:0]            r_rr;
    logic                  w_tick;
    logic [NUM_MOTORS-1:0] w_step;
    logic [NUM_MOTORS-1:0] w_served;

    assign w_tick = (r_div == DIV_W'(RAMP_DIV - 1));

    always_comb begin
        w_step   = '0;
        w_served = '0;
        for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
            w_step[i]   = w_tick && (r_tbl[i] != r_tgt[i]);
            w_served[i] = (r_rr == 5'(i));
        end
    end

    // Update pulses are reported by a pointer sweeping the change mask, one entry per cycle.
    assign period_upd = |(r_chg & w_served);
    assign upd_addr   = r_rr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= '0;
            r_chg <= '0;
            r_rr  <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            r_chg <= (r_chg & ~w_served) | w_step;
            r_rr  <= (r_rr == LAST_IDX) ? '0 : r_rr + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
                r_tbl[i] <= DEF_P;
                r_tgt[i] <= DEF_P;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
                if (w_wr_en && (w_wr_addr == 5'(i))) r_tgt[i] <= w_wr_val;
                if (w_step[i])
                    r_tbl[i] <= (r_tbl[i] < r_tgt[i]) ? r_tbl[i] + PERIOD_W'(1)
                                                      : r_tbl[i] - PERIOD_W'(1);
            end
        end
    end
`else
    logic w_unused_ramp;
    assign w_unused_ramp = (RAMP_DIV == 0);

    assign period_upd = w_wr_en;
    assign upd_addr   = w_wr_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_MOTORS; i++) r_tbl[i] <= DEF_P;
        end else begin
            for (int unsigned i = 0; i < NUM_MOTORS; i++)
                if (w_wr_en && (w_wr_addr == 5'(i))) r_tbl[i] <= w_wr_val;
        end
    end
`endif

    always_comb begin
        periods = '0;
        for (int unsigned i = 0; i < NUM_MOTORS; i++)
            periods[i*PERIOD_W +: PERIOD_W] = r_tbl[i];
    end

    assign resp_word = r_resp;
    assign busy      = r_busy;
    assign err_count = r_err;

endmodule

// File: tb/tb_motor_cmd_sched.sv
// Randomized self-checking bench for motor_cmd_sched against a command-level table/response model.
module tb_motor_cmd_sched;

    localparam int unsigned NM = 24;
    localparam int unsigned PW = 11;
    localparam int unsigned FW = NM * PW;

    logic          clk = 1'b0;
    logic          reset;
    logic          data_ready;
    logic [31:0]   cmd_word;
    logic [31:0]   enc_status;
    logic [31:0]   resp_word;
    logic [FW-1:0] periods;
    logic          period_upd;
    logic [4:0]    upd_addr;
    logic          busy;
    logic [7:0]    err_count;

    motor_cmd_sched #(
        .NUM_MOTORS    (NM),
        .PERIOD_W      (PW),
        .DEFAULT_PERIOD(1),
        .RAMP_DIV      (1024)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_ready(data_ready),
        .cmd_word  (cmd_word),
        .enc_status(enc_status),
        .resp_word (resp_word),
        .periods   (periods),
        .period_upd(period_upd),
        .upd_addr  (upd_addr),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [PW-1:0] mtbl [NM];
    int            merr;
    logic [31:0]   mresp;
    int            exp_q[$];
    int            got_q[$];
    int            got_c[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset && period_upd) begin
            got_q.push_back(int'(upd_addr));
            got_c.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] model_flat();
        logic [FW-1:0] f;
        f = '0;
        for (int i = 0; i < NM; i++) f[i*PW +: PW] = mtbl[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NM; i++) mtbl[i] = PW'(1);
        merr  = 0;
        mresp = '0;
    endtask

    task automatic model_err(input logic [7:0] op);
        merr  = (merr < 255) ? merr + 1 : 255;
        mresp = {16'hDEAD, op, 8'h00};
    endtask

    task automatic model_cmd(input logic [31:0] w, input logic [31:0] enc);
        logic [7:0] op;
        int         m;
        op = w[31:24];
        m  = int'(w[20:16]);
        if (op == 8'h00) begin
            if (m < NM) begin
                mtbl[m] = w[10:0];
                exp_q.push_back(m);
            end else model_err(op);
        end else if (op == 8'h01) begin
            if (w[23:16] == 8'h00)      mresp = enc;
            else if (w[23:16] == 8'h01) mresp = {16'h0000, 8'(merr), 8'h00};
            else                        model_err(op);
        end else if (op == 8'h02) begin
            for (int i = 0; i < NM; i++) begin
                mtbl[i] = w[10:0];
                exp_q.push_back(i);
            end
        end else model_err(op);
    endtask

    task automatic send_cmd(input logic [31:0] w, input logic [31:0] enc, input bit chk_busy,
                            output int t_rise);
        @(posedge clk); #1;
        cmd_word   = w;
        enc_status = enc;
        data_ready = 1'b1;
        t_rise     = cyc;
        repeat (2) @(posedge clk);
        #1;
        if (chk_busy) check("busy_before_evt", busy, 0);
        @(posedge clk); #1;
        if (chk_busy) check("busy_rise", busy, 1);
        @(posedge clk); #1;
        data_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int low;
        int n;
        low = 0;
        n   = 0;
        while (low < 3 && n < 300) begin
            @(posedge clk); #1;
            low = busy ? 0 : low + 1;
            n++;
        end
        check("idle_timeout", low >= 3, 1);
    endtask

    task automatic finish_cmd(input int t_rise, input int nconsec);
        int n;
        wait_idle();
        check("periods", periods, model_flat());
        check("err_count", err_count, merr);
        check("resp_word", resp_word, mresp);
        check("upd_count", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check("upd_addr", got_q[i], exp_q[i]);
        if (n > 0) check("upd_latency", (got_c[0] - t_rise >= 5) && (got_c[0] - t_rise <= 6), 1);
        for (int i = 1; i < n && i < nconsec; i++) check("upd_spacing", got_c[i] - got_c[0], i);
        got_q.delete();
        got_c.delete();
        exp_q.delete();
    endtask

    function automatic logic [31:0] rand_cmd();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0, 1: w[31:24] = 8'h00;
            2:    w[31:24] = 8'h02;
            3: begin
                w[31:24] = 8'h01;
                w[23:16] = 8'($urandom_range(0, 3));
            end
            4: w[31:24] = 8'($urandom_range(3, 255));
            default: begin
                w[31:24] = 8'h00;
                w[20:16] = 5'($urandom_range(0, NM - 1));
                w[10:0]  = ($urandom_range(0, 1) == 0) ? 11'h000 : 11'h7FF;
            end
        endcase
        return w;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int ta;
        logic [31:0] w;
        logic [31:0] e;

        reset      = 1'b0;
        data_ready = 1'b0;
        cmd_word   = '0;
        enc_status = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_periods", periods, model_flat());
        check("rst_resp", resp_word, 0);
        check("rst_err", err_count, 0);
        check("rst_upd", period_upd, 0);
        check("rst_addr", upd_addr, 0);
        check("rst_busy", busy, 0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        send_cmd(32'h0005_03E8, 32'h0, 1, t0);
        model_cmd(32'h0005_03E8, 32'h0);
        finish_cmd(t0, 1);

        send_cmd(32'h0200_0064, 32'h0, 1, t0);
        model_cmd(32'h0200_0064, 32'h0);
        finish_cmd(t0, NM);

        send_cmd(32'h0100_0000, 32'h0000_01A7, 1, t0);
        model_cmd(32'h0100_0000, 32'h0000_01A7);
        finish_cmd(t0, 0);

        send_cmd(32'h7F00_0000, 32'h0, 1, t0);
        model_cmd(32'h7F00_0000, 32'h0);
        finish_cmd(t0, 0);
        send_cmd(32'h001E_0010, 32'h0, 1, t0);
        model_cmd(32'h001E_0010, 32'h0);
        finish_cmd(t0, 0);

        send_cmd(32'h0101_0000, 32'h0, 1, t0);
        model_cmd(32'h0101_0000, 32'h0);
        finish_cmd(t0, 0);

        send_cmd(32'h0105_0000, 32'h0, 1, t0);
        model_cmd(32'h0105_0000, 32'h0);
        finish_cmd(t0, 0);

        // Two extra words during a broadcast: first is queued, second is lost.
        send_cmd(32'h0200_0123, 32'h0, 1, t0);
        model_cmd(32'h0200_0123, 32'h0);
        while (cyc < t0 + 7) @(posedge clk);
        send_cmd(32'h0001_0007, 32'h0, 0, ta);
        while (cyc < t0 + 15) @(posedge clk);
        send_cmd(32'h0002_0008, 32'h0, 0, ta);
        model_err(8'h00);
        model_cmd(32'h0002_0008, 32'h0);
        finish_cmd(t0, NM);

        send_cmd(32'h0200_0055, 32'h0, 1, t0);
        repeat (10) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        model_reset();
        check("rst_mid_periods", periods, model_flat());
        check("rst_mid_busy", busy, 0);
        check("rst_mid_upd", period_upd, 0);
        check("rst_mid_err", err_count, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        got_q.delete();
        got_c.delete();
        exp_q.delete();
        repeat (30) @(posedge clk);
        #1;
        check("rst_no_upd", got_q.size(), 0);
        check("rst_post_periods", periods, model_flat());
        check("rst_post_busy", busy, 0);

        for (int k = 0; k < 40; k++) begin
            w = rand_cmd();
            e = $urandom;
            send_cmd(w, e, 1, t0);
            model_cmd(w, e);
            finish_cmd(t0, exp_q.size());
        end

        for (int k = 0; k < 258; k++) begin
            w = {8'($urandom_range(3, 255)), 24'($urandom)};
            send_cmd(w, 32'h0, 0, t0);
            model_cmd(w, 32'h0);
            wait_idle();
        end
        finish_cmd(t0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
